// File: rtl/rv32i_pkg.sv
// Shared definitions for the fetch-side branch predictor.
//   ctr_t   : 2-bit bimodal counter encoding (MSB = predict taken)
//   PC_STEP : sequential instruction stride used for fall-through redirects
package rv32i_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state logic for a 2-bit saturating up/down counter.
// Ports:
//   ctr      in   current counter value
//   up       in   1 = step toward ST, 0 = step toward SNT
//   ctr_next out  counter value after the step (holds at SNT and ST)
module bp_sat_ctr
  import rv32i_pkg::*;
(
  input  ctr_t ctr,
  input  logic up,
  output ctr_t ctr_next
);

  always_comb begin
    ctr_next = ctr;
    case (ctr)
      SNT:     ctr_next = up ? WNT : SNT;
      WNT:     ctr_next = up ? WT  : SNT;
      WT:      ctr_next = up ? ST  : WNT;
      ST:      ctr_next = up ? ST  : WT;
      default: ctr_next = ctr;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal direction predictor with a direct-mapped BTB.
// Fetch looks up direction/target combinationally; resolved branches from
// execute train the tables and raise a registered one-cycle flush on mispredict.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   if_valid, if_pc             fetch lookup request
//   pred_taken, pred_target     combinational prediction for if_pc
//   ex_valid, ex_pc, ex_taken,  resolved conditional branch
//   ex_target, ex_pred_taken,
//   ex_pred_target              prediction that travelled with the branch
//   flush, redirect_pc          registered mispredict pulse and corrected PC
//   mispred_cnt                 running mispredict count (wraps)
module branch_predictor
  import rv32i_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic [31:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_LO  = IDX_BITS + 2;
  localparam int TAG_HI  = IDX_BITS + TAG_BITS + 1;

  logic                valid_tbl [ENTRIES];
  logic [TAG_BITS-1:0] tag_tbl   [ENTRIES];
  logic [31:0]         tgt_tbl   [ENTRIES];
  ctr_t                ctr_tbl   [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0] if_tag, ex_tag;
  logic                if_hit, ex_hit;
  logic                mispredict;
  ctr_t                ctr_upd;

  // Byte-offset bits and PC bits above the tag take no part in the lookup.
  logic unused_if_pc_bits;
  assign unused_if_pc_bits = ^{if_pc[1:0], if_pc[31:TAG_HI+1]};

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[TAG_HI:TAG_LO];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[TAG_HI:TAG_LO];

  // Lookup reads the registered tables only, so a same-cycle update is not
  // visible until the following cycle.
  assign if_hit      = valid_tbl[if_idx] && (tag_tbl[if_idx] == if_tag);
  assign pred_taken  = if_valid && if_hit && ctr_tbl[if_idx][1];
  assign pred_target = if_hit ? tgt_tbl[if_idx] : '0;

  assign ex_hit = valid_tbl[ex_idx] && (tag_tbl[ex_idx] == ex_tag);

  assign mispredict = ex_valid &&
                      ((ex_taken != ex_pred_taken) ||
                       (ex_taken && ex_pred_taken && (ex_target != ex_pred_target)));

  bp_sat_ctr u_sat_ctr (
    .ctr      (ctr_tbl[ex_idx]),
    .up       (ex_taken),
    .ctr_next (ctr_upd)
  );

  // Valid bits and counters carry the reset; tags and targets are only
  // meaningful behind a set valid bit, so they need none.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_tbl[i] <= 1'b0;
        ctr_tbl[i]   <= WNT;
      end
    end else if (ex_valid) begin
      if (ex_hit) begin
        ctr_tbl[ex_idx] <= ctr_upd;
      end else if (ex_taken) begin
        valid_tbl[ex_idx] <= 1'b1;
        ctr_tbl[ex_idx]   <= WT;
      end
    end
  end

  // Any taken resolution either refreshes a hit entry's target or allocates;
  // rewriting the tag on a hit is harmless because it already matches.
  always_ff @(posedge clk) begin
    if (ex_valid && ex_taken) begin
      tag_tbl[ex_idx] <= ex_tag;
      tgt_tbl[ex_idx] <= ex_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush       <= 1'b0;
      redirect_pc <= '0;
      mispred_cnt <= '0;
    end else begin
      flush <= mispredict;
      if (mispredict) begin
        redirect_pc <= ex_taken ? ex_target : (ex_pc + PC_STEP);
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

endmodule
